uart_rx: RTL



---
 rtl/uart_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, one-cycle
// byte-valid and framing-error strobes, and break absorption.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [20:0] HALF = 21'((CLKS_PER_BIT - 1) / 2);
    localparam logic [20:0] FULL = 21'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_STOP    = 3'd3,
        s_CLEANUP = 3'd4,
        s_BREAK   = 3'd5
    } state_t;

    logic        rx_meta;
    logic        rx;
    state_t      state;
    state_t      state_next;
    logic [20:0] clk_count;
    logic [20:0] count_next;
    logic [2:0]  bit_index;
    logic [2:0]  index_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic        dv_next;
    logic        err_next;
    logic        active_next;
    logic [7:0]  byte_next;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta     <= 1'b1;
            rx          <= 1'b1;
            state       <= s_IDLE;
            clk_count   <= '0;
            bit_index   <= '0;
            shift       <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= 8'h00;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            rx_meta     <= i_Rx_Serial;
            rx          <= rx_meta;
            state       <= state_next;
            clk_count   <= count_next;
            bit_index   <= index_next;
            shift       <= shift_next;
            o_Rx_DV     <= dv_next;
            o_Rx_Byte   <= byte_next;
            o_Rx_Active <= active_next;
            o_Frame_Err <= err_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        count_next = clk_count;
        index_next = bit_index;
        shift_next = shift;
        case (state)
            s_IDLE: begin
                count_next = '0;
                index_next = '0;
                if (!rx) state_next = s_START;
            end
            s_START: begin
                if (clk_count == HALF) begin
                    count_next = '0;
                    // A start bit that is high again at its midpoint was a glitch.
                    state_next = rx ? s_IDLE : s_DATA;
                end else begin
                    count_next = clk_count + 21'd1;
                end
            end
            s_DATA: begin
                if (clk_count == FULL) begin
                    count_next            = '0;
                    shift_next[bit_index] = rx;
                    if (bit_index < 3'd7) begin
                        index_next = bit_index + 3'd1;
                    end else begin
                        index_next = '0;
                        state_next = s_STOP;
                    end
                end else begin
                    count_next = clk_count + 21'd1;
                end
            end
            s_STOP: begin
                if (clk_count == FULL) begin
                    count_next = '0;
                    state_next = rx ? s_CLEANUP : s_BREAK;
                end else begin
                    count_next = clk_count + 21'd1;
                end
            end
            s_CLEANUP: begin
                count_next = '0;
                state_next = s_IDLE;
            end
            s_BREAK: begin
                count_next = '0;
                if (rx) state_next = s_IDLE;
            end
            default: begin
                count_next = '0;
                index_next = '0;
                state_next = s_IDLE;
            end
        endcase
    end

    // Output strobes fire on the stop-bit sample; they are registered above.
    always_comb begin
        dv_next     = (state == s_STOP) && (clk_count == FULL) && rx;
        err_next    = (state == s_STOP) && (clk_count == FULL) && !rx;
        byte_next   = dv_next ? shift : o_Rx_Byte;
        active_next = (state_next != s_IDLE);
    end

endmodule
